// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_arbiter
// Purpose  : Round-robin, dwell-limited sharing of a six-digit active-low
//            seven-segment bank between two requesting message sources.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_arbiter #(
   parameter int TICK_DIV    = 50_000_000,
   parameter int DWELL_TICKS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [23:0] msg0,
   input  logic        req1,
   input  logic [23:0] msg1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        busy,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DWELL_TICKS + 1);

   localparam logic [PW-1:0] c_TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] c_DWELL_MAX = DW'(DWELL_TICKS);
   localparam logic [DW-1:0] c_DWELL_PRE = DW'(DWELL_TICKS - 1);
   localparam logic [6:0]    c_BLANK     = 7'b1111111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN0 = 2'd1,
      S_OWN1 = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_last;
   logic [PW-1:0]   r_presc;
   logic [DW-1:0]   r_dwell;

   state_t          w_next;
   logic            w_tick;
   logic            w_expired;
   logic            w_grant;
   logic [23:0]     w_msg;
   logic [6:0]      w_hex [6];

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0:    seg7 = 7'b1000000;
         4'h1:    seg7 = 7'b1111001;
         4'h2:    seg7 = 7'b0100100;
         4'h3:    seg7 = 7'b0110000;
         4'h4:    seg7 = 7'b0011001;
         4'h5:    seg7 = 7'b0010010;
         4'h6:    seg7 = 7'b0000010;
         4'h7:    seg7 = 7'b1111000;
         4'h8:    seg7 = 7'b0000000;
         4'h9:    seg7 = 7'b0010000;
         4'hC:    seg7 = 7'b1000110;
         4'hE:    seg7 = 7'b0000110;
         default: seg7 = c_BLANK;
      endcase
   endfunction

   assign w_tick = (r_state != S_IDLE) && (r_presc == c_TICK_LAST);

   // Counting the tick that completes the dwell lets the switch happen on
   // that edge, making a contested dwell exactly DWELL_TICKS*TICK_DIV cycles.
   assign w_expired = (r_dwell == c_DWELL_MAX) ||
                      (w_tick && (r_dwell == c_DWELL_PRE));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req0 && req1)
               w_next = r_last ? S_OWN0 : S_OWN1;
            else if (req0)
               w_next = S_OWN0;
            else if (req1)
               w_next = S_OWN1;
         end
         S_OWN0: begin
            if (!req0)
               w_next = req1 ? S_OWN1 : S_IDLE;
            else if (w_expired && req1)
               w_next = S_OWN1;
         end
         S_OWN1: begin
            if (!req1)
               w_next = req0 ? S_OWN0 : S_IDLE;
            else if (w_expired && req0)
               w_next = S_OWN0;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_grant = (w_next != S_IDLE) && (w_next != r_state);
   assign w_msg   = (w_next == S_OWN1) ? msg1 : msg0;

   always_comb begin
      for (int k = 0; k < 6; k++) begin
         w_hex[k] = (w_next == S_IDLE) ? c_BLANK : seg7(w_msg[4*k +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_presc <= '0;
         r_dwell <= '0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         busy    <= 1'b0;
         HEX0    <= c_BLANK;
         HEX1    <= c_BLANK;
         HEX2    <= c_BLANK;
         HEX3    <= c_BLANK;
         HEX4    <= c_BLANK;
         HEX5    <= c_BLANK;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_last  <= (w_next == S_OWN1);
            r_presc <= '0;
            r_dwell <= '0;
         end else if (w_next == S_IDLE) begin
            r_presc <= '0;
            r_dwell <= '0;
         end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick && (r_dwell != c_DWELL_MAX))
               r_dwell <= r_dwell + DW'(1);
         end
         gnt0 <= (w_next == S_OWN0);
         gnt1 <= (w_next == S_OWN1);
         busy <= (w_next != S_IDLE);
         HEX0 <= w_hex[0];
         HEX1 <= w_hex[1];
         HEX2 <= w_hex[2];
         HEX3 <= w_hex[3];
         HEX4 <= w_hex[4];
         HEX5 <= w_hex[5];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_arbiter
// Purpose  : Directed scenarios plus randomized traffic against an ownership
//            model of hex_display_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_arbiter;

   localparam int TICK_DIV    = 4;
   localparam int DWELL_TICKS = 2;
   localparam int DWELL_CYC   = TICK_DIV * DWELL_TICKS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [23:0] msg0 = '0;
   logic [23:0] msg1 = '0;
   logic        gnt0, gnt1, busy;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   hex_display_arbiter #(.TICK_DIV(TICK_DIV), .DWELL_TICKS(DWELL_TICKS)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .msg0(msg0), .req1(req1), .msg1(msg1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
      .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
      7'b1000110, 7'b1111111, 7'b0000110, 7'b1111111 };

   // Model: owner 0 = nobody, 1 = requester 0, 2 = requester 1.
   int          m_owner = 0;
   int          m_last  = 1;
   int          m_k     = 0;
   int          m_new;
   logic        m_valid = 1'b0;
   logic        m_own_req, m_oth_req;
   logic [23:0] m_msg;
   logic [6:0]  m_hex [6];

   always @(posedge clk) begin
      if (rst) begin
         m_owner = 0;
         m_last  = 1;
         m_k     = 0;
         m_valid = 1'b1;
      end else begin
         m_new = m_owner;
         if (m_owner == 0) begin
            if (req0 && req1)  m_new = (m_last == 1) ? 1 : 2;
            else if (req0)     m_new = 1;
            else if (req1)     m_new = 2;
         end else begin
            m_k++;
            m_own_req = (m_owner == 1) ? req0 : req1;
            m_oth_req = (m_owner == 1) ? req1 : req0;
            if (!m_own_req)
               m_new = m_oth_req ? 3 - m_owner : 0;
            else if (m_k >= DWELL_CYC && m_oth_req)
               m_new = 3 - m_owner;
         end
         if (m_new != m_owner) begin
            m_k = 0;
            if (m_new != 0) m_last = m_new - 1;
         end
         m_owner = m_new;
      end
      m_msg = (m_owner == 2) ? msg1 : msg0;
      for (int k = 0; k < 6; k++)
         m_hex[k] = (m_owner == 0) ? 7'h7F : seg_tab[m_msg[4*k +: 4]];
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("gnt0", 7'(gnt0), 7'(m_owner == 1));
         chk("gnt1", 7'(gnt1), 7'(m_owner == 2));
         chk("busy", 7'(busy), 7'(m_owner != 0));
         chk("no_overlap", 7'(gnt0 & gnt1), 7'd0);
         chk("HEX0", HEX0, m_hex[0]);
         chk("HEX1", HEX1, m_hex[1]);
         chk("HEX2", HEX2, m_hex[2]);
         chk("HEX3", HEX3, m_hex[3]);
         chk("HEX4", HEX4, m_hex[4]);
         chk("HEX5", HEX5, m_hex[5]);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      cyc(3);
      rst  = 1'b0;
   endtask

   task automatic chk_blank(input string name);
      chk({name, "_H0"}, HEX0, 7'h7F);
      chk({name, "_H1"}, HEX1, 7'h7F);
      chk({name, "_H2"}, HEX2, 7'h7F);
      chk({name, "_H3"}, HEX3, 7'h7F);
      chk({name, "_H4"}, HEX4, 7'h7F);
      chk({name, "_H5"}, HEX5, 7'h7F);
   endtask

   initial begin
      int waited;
      @(negedge clk);
      do_reset();
      chk_blank("rst");
      chk("rst_gnt0", 7'(gnt0), 7'd0);
      chk("rst_gnt1", 7'(gnt1), 7'd0);
      chk("rst_busy", 7'(busy), 7'd0);

      // Single requester decode
      req0 = 1'b1;
      msg0 = 24'hEC1087;
      cyc(1);
      chk("dec_gnt0", 7'(gnt0), 7'd1);
      chk("dec_H5", HEX5, 7'b0000110);
      chk("dec_H4", HEX4, 7'b1000110);
      chk("dec_H3", HEX3, 7'b1111001);
      chk("dec_H2", HEX2, 7'b1000000);
      chk("dec_H1", HEX1, 7'b0000000);
      chk("dec_H0", HEX0, 7'b1111000);
      cyc(30);
      chk("hold_gnt0", 7'(gnt0), 7'd1);

      // Simultaneous requests from reset
      do_reset();
      msg1 = 24'h123456;
      req0 = 1'b1;
      req1 = 1'b1;
      cyc(DWELL_CYC);
      chk("sim_gnt0_end", 7'(gnt0), 7'd1);
      cyc(1);
      chk("sim_gnt1_start", 7'(gnt1), 7'd1);
      cyc(DWELL_CYC - 1);
      chk("sim_gnt1_end", 7'(gnt1), 7'd1);
      cyc(1);
      chk("sim_gnt0_again", 7'(gnt0), 7'd1);

      // Late contender
      do_reset();
      req0 = 1'b1;
      cyc(2);
      req1 = 1'b1;
      cyc(6);
      chk("late_gnt0_held", 7'(gnt0), 7'd1);
      cyc(1);
      chk("late_gnt1", 7'(gnt1), 7'd1);
      req1 = 1'b0;
      cyc(1);
      chk("late_back_gnt0", 7'(gnt0), 7'd1);

      // Early release with a partly-blank message
      do_reset();
      msg0 = 24'hABDF00;
      req0 = 1'b1;
      cyc(1);
      chk("abdf_H5", HEX5, 7'h7F);
      chk("abdf_H2", HEX2, 7'h7F);
      chk("abdf_H1", HEX1, 7'b1000000);
      chk("abdf_H0", HEX0, 7'b1000000);
      cyc(2);
      req0 = 1'b0;
      cyc(1);
      chk("rel_gnt0", 7'(gnt0), 7'd0);
      chk("rel_busy", 7'(busy), 7'd0);
      chk_blank("rel");

      // Mid-dwell reset while requester 1 owns
      req0 = 1'b1;
      req1 = 1'b1;
      waited = 0;
      while (gnt1 !== 1'b1 && waited < 40) begin
         cyc(1);
         waited++;
      end
      chk("wait_gnt1", 7'(gnt1), 7'd1);
      cyc(2);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("mrst_gnt1", 7'(gnt1), 7'd0);
      chk("mrst_busy", 7'(busy), 7'd0);
      chk_blank("mrst");
      cyc(1);
      chk("mrst_gnt0_first", 7'(gnt0), 7'd1);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cyc(1);
         if ($urandom_range(7) == 0)  req0 = ~req0;
         if ($urandom_range(7) == 0)  req1 = ~req1;
         if ($urandom_range(3) == 0)  msg0 = 24'($urandom);
         if ($urandom_range(3) == 0)  msg1 = 24'($urandom);
         rst = ($urandom_range(399) == 0);
      end
      rst = 1'b0;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
